// File: rtl/eth_reset_sequencer_pkg.sv
// eth_reset_pkg: shared types and helpers for the Ethernet reset sequencer.
//   eth_reset_state_e : sequencer FSM states
//   *_DEF localparams : default phase lengths in clk cycles
//   cnt_width()       : width of the shared phase counter
package eth_reset_pkg;

  typedef enum logic [1:0] {
    PHY_RST    = 2'd0,
    PHY_SETTLE = 2'd1,
    LINK_WAIT  = 2'd2,
    RUN        = 2'd3
  } eth_reset_state_e;

  localparam int unsigned PHY_HOLD_CYCLES_DEF    = 1024;
  localparam int unsigned PHY_SETTLE_CYCLES_DEF  = 256;
  localparam int unsigned LINK_TIMEOUT_CYCLES_DEF = 65536;

  // Enough bits to hold the largest terminal count of any phase.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/eth_reset_sequencer_if.sv
// eth_reset_sequencer_if: control/status bundle of the reset sequencer.
//   soft_reset_i  : single-cycle request to restart the sequence
//   phy_ready_i   : PHY ready/locked, synchronous to the sequencer clock
//   phy_reset_n_o : active-low PHY reset
//   mac_reset_o   : active-high MAC reset
//   ready_o       : sequence complete, MAC running
//   timeout_o     : one-cycle pulse on a link-wait timeout
// master = the sequencer, slave = the logic around it.
interface eth_reset_sequencer_if;
  logic soft_reset_i;
  logic phy_ready_i;
  logic phy_reset_n_o;
  logic mac_reset_o;
  logic ready_o;
  logic timeout_o;

  modport master (
    input  soft_reset_i, phy_ready_i,
    output phy_reset_n_o, mac_reset_o, ready_o, timeout_o
  );

  modport slave (
    output soft_reset_i, phy_ready_i,
    input  phy_reset_n_o, mac_reset_o, ready_o, timeout_o
  );
endinterface

// File: rtl/eth_reset_counter.sv
// eth_reset_counter: clearable, enable-gated up counter with terminal compare.
//   clk_i  : clock
//   clr_i  : synchronous clear to zero (wins over en_i)
//   en_i   : count enable
//   term_i : terminal value
//   cnt_o  : current count
//   tc_o   : cnt_o == term_i
module eth_reset_counter #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [width_p-1:0] term_i,
  output logic [width_p-1:0] cnt_o,
  output logic               tc_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

  assign tc_o = (cnt_o == term_i);

endmodule

// File: rtl/eth_reset_sequencer.sv
// eth_reset_sequencer: sequences PHY and MAC reset release after the
// synchronized reset or a software restart request.
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : eth_reset_sequencer_if.master (soft_reset_i, phy_ready_i in;
//             phy_reset_n_o, mac_reset_o, ready_o, timeout_o out)
// Optional feature macro: ETH_RESET_SEQ_LINK_WAIT_EN adds the LINK_WAIT
// state (wait for phy_ready_i with timeout). Without it PHY_SETTLE goes
// straight to RUN and timeout_o is tied low.
module eth_reset_sequencer
  import eth_reset_pkg::*;
#(
  parameter int unsigned phy_hold_cycles_p     = PHY_HOLD_CYCLES_DEF,
  parameter int unsigned phy_settle_cycles_p   = PHY_SETTLE_CYCLES_DEF,
  parameter int unsigned link_timeout_cycles_p = LINK_TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  eth_reset_sequencer_if.master bus
);

  localparam int unsigned cnt_w_lp =
    cnt_width(phy_hold_cycles_p, phy_settle_cycles_p, link_timeout_cycles_p);

  if (phy_hold_cycles_p < 1) begin : g_hold_chk
    $error("phy_hold_cycles_p must be >= 1");
  end
  if (phy_settle_cycles_p < 1) begin : g_settle_chk
    $error("phy_settle_cycles_p must be >= 1");
  end
  if (link_timeout_cycles_p < 1) begin : g_timeout_chk
    $error("link_timeout_cycles_p must be >= 1");
  end

  eth_reset_state_e      state_r, state_n;
  logic [cnt_w_lp-1:0]   cnt_r, term;
  logic                  tc, cnt_clr, cnt_en;
  logic                  ready_r;

  // Every state change restarts the shared counter, so each phase counts from 0.
  assign cnt_clr = reset_i || bus.soft_reset_i || (state_n != state_r);
  assign cnt_en  = (state_r != RUN);

  eth_reset_counter #(.width_p(cnt_w_lp)) u_cnt (
    .clk_i  (clk_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (term),
    .cnt_o  (cnt_r),
    .tc_o   (tc)
  );

  always_comb begin
    term = '0;
    case (state_r)
      PHY_RST:    term = cnt_w_lp'(phy_hold_cycles_p - 1);
      PHY_SETTLE: term = cnt_w_lp'(phy_settle_cycles_p - 1);
`ifdef ETH_RESET_SEQ_LINK_WAIT_EN
      LINK_WAIT:  term = cnt_w_lp'(link_timeout_cycles_p - 1);
`endif
      default:    term = '0;
    endcase
  end

`ifdef ETH_RESET_SEQ_LINK_WAIT_EN
  logic timeout_n, timeout_r;

  always_comb begin
    state_n   = state_r;
    timeout_n = 1'b0;
    if (bus.soft_reset_i) begin
      state_n = PHY_RST;
    end else begin
      case (state_r)
        PHY_RST:    if (tc) state_n = PHY_SETTLE;
        PHY_SETTLE: if (tc) state_n = LINK_WAIT;
        LINK_WAIT: begin
          // phy_ready_i takes precedence over a coincident timeout
          if (bus.phy_ready_i) begin
            state_n = RUN;
          end else if (tc) begin
            state_n   = PHY_RST;
            timeout_n = 1'b1;
          end
        end
        RUN:        state_n = RUN;
        default:    state_n = PHY_RST;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) timeout_r <= 1'b0;
    else         timeout_r <= timeout_n;
  end

  assign bus.timeout_o = timeout_r;
`else
  logic unused_phy_ready;
  assign unused_phy_ready = bus.phy_ready_i;

  always_comb begin
    state_n = state_r;
    if (bus.soft_reset_i) begin
      state_n = PHY_RST;
    end else begin
      case (state_r)
        PHY_RST:    if (tc) state_n = PHY_SETTLE;
        PHY_SETTLE: if (tc) state_n = RUN;
        RUN:        state_n = RUN;
        default:    state_n = PHY_RST;
      endcase
    end
  end

  assign bus.timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= PHY_RST;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_n;
      ready_r <= (state_r == RUN);
    end
  end

  assign bus.phy_reset_n_o = (state_r != PHY_RST);
  assign bus.mac_reset_o   = (state_r != RUN);
  assign bus.ready_o       = ready_r;

endmodule

// File: tb/tb_eth_reset_sequencer.sv
module tb_eth_reset_sequencer;

  localparam int unsigned H = 8;
  localparam int unsigned S = 4;
  localparam int unsigned T = 16;
`ifdef ETH_RESET_SEQ_LINK_WAIT_EN
  localparam bit lw_en = 1'b1;
`else
  localparam bit lw_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  eth_reset_sequencer_if bus ();

  eth_reset_sequencer #(
    .phy_hold_cycles_p     (H),
    .phy_settle_cycles_p   (S),
    .link_timeout_cycles_p (T)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: t_m = edges elapsed since the current sequence began,
  // run_m = MAC released, rdy_m = ready expectation, to_m = timeout pulse.
  int unsigned t_m   = 0;
  logic        run_m = 1'b0;
  logic        rdy_m = 1'b0;
  logic        to_m  = 1'b0;
  int unsigned n_to  = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b (t=%0d)", tag, obs, exp, t_m);
    end
  endtask

  task automatic check_int(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p);
    int unsigned tb;
    reset            = r;
    bus.soft_reset_i = s;
    bus.phy_ready_i  = p;
    @(posedge clk);
    tb    = t_m;
    rdy_m = run_m;
    to_m  = 1'b0;
    if (r || s) begin
      t_m   = 0;
      run_m = 1'b0;
      if (r) rdy_m = 1'b0;
    end else if (!run_m) begin
      t_m = t_m + 1;
      if (lw_en) begin
        if (tb >= H + S) begin
          if (p) run_m = 1'b1;
          else if (tb == H + S + T - 1) begin
            t_m  = 0;
            to_m = 1'b1;
          end
        end
      end else if (t_m >= H + S) begin
        run_m = 1'b1;
      end
    end
    #1;
    check("phy_reset_n", bus.phy_reset_n_o, run_m || (t_m >= H));
    check("mac_reset",   bus.mac_reset_o,   !run_m);
    check("ready",       bus.ready_o,       rdy_m);
    check("timeout",     bus.timeout_o,     to_m);
    if (bus.timeout_o === 1'b1) n_to++;
  endtask

  // Runs n idle steps and records the step index of each release event.
  task automatic measure(input int unsigned n, input logic p,
                         output int unsigned rise, output int unsigned fall,
                         output int unsigned rrise, output int unsigned mac_early);
    rise = 0; fall = 0; rrise = 0; mac_early = 0;
    for (int unsigned i = 1; i <= n; i++) begin
      step(1'b0, 1'b0, p);
      if (rise == 0 && bus.phy_reset_n_o === 1'b1) rise = i;
      if (fall == 0 && bus.mac_reset_o === 1'b0) fall = i;
      if (rrise == 0 && bus.ready_o === 1'b1) rrise = i;
      if (rise == 0 && bus.mac_reset_o !== 1'b1) mac_early++;
    end
  endtask

  initial begin
    int unsigned rise, fall, rrise, early;
    bus.soft_reset_i = 1'b0;
    bus.phy_ready_i  = 1'b0;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Cold start
    measure(40, 1'b1, rise, fall, rrise, early);
    check_int("cold_phy_rise", rise, H);
    check_int("cold_mac_fall", fall, H + S + (lw_en ? 1 : 0));
    check_int("cold_ready_rise", rrise, H + S + (lw_en ? 2 : 1));

    // Soft reset from RUN: outputs reset right away, ready lags by one
    step(1'b0, 1'b1, 1'b1);
    check("soft_ready_lag", bus.ready_o, 1'b1);
    measure(20, 1'b1, rise, fall, rrise, early);
    check_int("soft_phy_rise", rise, H);
    check_int("soft_mac_fall", fall, H + S + (lw_en ? 1 : 0));

    // Soft reset during PHY_SETTLE restarts from the beginning
    step(1'b0, 1'b1, 1'b1);
    repeat (H + 1) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    measure(20, 1'b1, rise, fall, rrise, early);
    check_int("midsettle_phy_rise", rise, H);
    check_int("midsettle_mac_early", early, 0);

    // No PHY ready: exactly one timeout in the window (link-wait build)
    step(1'b0, 1'b1, 1'b0);
    n_to = 0;
    repeat (40) step(1'b0, 1'b0, 1'b0);
    check_int("timeout_pulses", n_to, lw_en ? 1 : 0);

    // Reset together with soft reset mid link-wait: cold-start timing
    step(1'b0, 1'b1, 1'b0);
    repeat (H + S + 2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    measure(30, 1'b1, rise, fall, rrise, early);
    check_int("rst_phy_rise", rise, H);
    check_int("rst_mac_fall", fall, H + S + (lw_en ? 1 : 0));
    check_int("rst_ready_rise", rrise, H + S + (lw_en ? 2 : 1));

    // PHY ready exactly at the timeout terminal count wins
    step(1'b0, 1'b1, 1'b0);
    repeat (H + S + T - 1) step(1'b0, 1'b0, 1'b0);
    n_to = 0;
    step(1'b0, 1'b0, 1'b1);
    check("terminal_ready_mac", bus.mac_reset_o, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check_int("terminal_no_timeout", n_to, 0);

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 600; i++) begin
      step(($urandom_range(0, 120) == 0),
           ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
